lhca8_checker: RTL

- Receive-side counterpart to the team's 8-bit LHCA pseudo-random generator.
  - Generator: rule 90/150 hybrid cellular automaton, null boundaries, bits 1 and 2 rule 150, all other bits rule 90, start state 0x01.
- Takes a stream of 8-bit words (e.g. sampled J3 bus or loopback), self-synchronises to the sequence, then checks every word against its own prediction.
- Reports lock status and saturating error/word counts; used for board-level link and PRBS bring-up on ice40.

---
 rtl/lhca_pkg.sv | 31 +++
 rtl/lhca8_sat_counter.sv | 33 +++
 rtl/lhca8_checker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lhca_pkg.sv
// lhca_pkg: shared definitions for the 8-bit rule 90/150 LHCA generator and checker.
// Latency: n/a (types, constants and a combinational step function only).
// Backpressure: n/a.
package lhca_pkg;

    // Cells using rule 150 (self term included); every other cell is rule 90.
    localparam logic [7:0] RULE150_MASK = 8'h06;
    localparam logic [7:0] LHCA_SEED    = 8'h01;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        SEARCH   = 2'd1,
        LOCKED   = 2'd2
    } chk_state_t;

    // One automaton step with null boundaries: left neighbour ^ right neighbour,
    // plus the cell itself on the rule-150 positions.
    function automatic logic [7:0] lhca_next(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ {1'b0, s[7:1]} ^ (s & RULE150_MASK);
    endfunction

    function automatic logic [3:0] lhca_popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lhca8_sat_counter.sv
// lhca8_sat_counter: counter that adds 0..8 per cycle and sticks at all-ones.
// Latency: 1 cycle from inc to count.
// Backpressure: none; inc=0 holds the value.
// Ports: CLK, RESET (sync, active high), inc[3:0] amount to add, count[W-1:0].
module lhca8_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   inc,
    output logic [W-1:0] count
);

    // Four guard bits hold count + 8 without wrapping for any W.
    localparam int WIDE = W + 4;

    logic [WIDE-1:0] sum;
    logic [W-1:0]    next_count;

    always_comb begin
        sum        = {4'd0, count} + {{W{1'b0}}, inc};
        next_count = (sum[WIDE-1:W] != 4'd0) ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/lhca8_checker.sv
// lhca8_checker: self-synchronising checker for the 8-bit LHCA PRBS stream.
// Latency: outputs update the cycle after a valid word is sampled.
// Backpressure: none; valid=0 holds all state. Optional macro LHCA_CHK_BITERR_EN adds bit_err_count.
// Ports: CLK, RESET (sync, active high), valid, data[7:0] in; locked, err_pulse,
//        err_count, word_count (and bit_err_count with the macro) out.
module lhca8_checker
    import lhca_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             valid,
    input  logic [7:0]       data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
`ifdef LHCA_CHK_BITERR_EN
    ,
    output logic [CNT_W-1:0] bit_err_count
`endif
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    chk_state_t state, state_d;
    logic [7:0] pred, pred_d;
    logic [3:0] match_run, match_run_d, match_run_inc;
    logic [3:0] miss_run, miss_run_d, miss_run_inc;
    logic       err_d;
    logic [3:0] err_inc, word_inc;
    logic       match, zero;

    assign match         = (data == pred);
    assign zero          = (data == 8'h00);
    // Runs never pass their thresholds (max 15), so a 4-bit increment cannot wrap.
    assign match_run_inc = match_run + 4'd1;
    assign miss_run_inc  = miss_run + 4'd1;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= UNSEEDED;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (valid) begin
            case (state)
                UNSEEDED: if (!zero) state_d = SEARCH;
                SEARCH: begin
                    if (zero) begin
                        state_d = UNSEEDED;
                    end else if (match && (match_run_inc >= LOCK_N)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: if (!match && (miss_run_inc >= LOSS_N)) state_d = UNSEEDED;
                default: state_d = UNSEEDED;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        pred_d      = pred;
        match_run_d = match_run;
        miss_run_d  = miss_run;
        err_d       = 1'b0;
        err_inc     = 4'd0;
        word_inc    = 4'd0;
        if (valid) begin
            case (state)
                UNSEEDED: begin
                    if (!zero) begin
                        pred_d      = lhca_next(data);
                        match_run_d = 4'd0;
                    end
                end
                SEARCH: begin
                    pred_d      = lhca_next(data);
                    match_run_d = (match && !zero) ? match_run_inc : 4'd0;
                    if (state_d == LOCKED) begin
                        match_run_d = 4'd0;
                        miss_run_d  = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction runs on its own, ignoring received data.
                    pred_d   = lhca_next(pred);
                    word_inc = 4'd1;
                    if (match) begin
                        miss_run_d = 4'd0;
                    end else begin
                        err_d      = 1'b1;
                        err_inc    = 4'd1;
                        miss_run_d = miss_run_inc;
                    end
                    if (state_d == UNSEEDED) miss_run_d = 4'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pred      <= 8'h00;
            match_run <= 4'd0;
            miss_run  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            pred      <= pred_d;
            match_run <= match_run_d;
            miss_run  <= miss_run_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= err_d;
        end
    end

    lhca8_sat_counter #(.W(CNT_W)) u_err_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (err_inc),
        .count (err_count)
    );

    lhca8_sat_counter #(.W(CNT_W)) u_word_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (word_inc),
        .count (word_count)
    );

`ifdef LHCA_CHK_BITERR_EN
    logic [3:0] bit_inc;
    assign bit_inc = (valid && state == LOCKED) ? lhca_popcount(data ^ pred) : 4'd0;

    lhca8_sat_counter #(.W(CNT_W)) u_bit_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (bit_inc),
        .count (bit_err_count)
    );
`endif

endmodule
